// File: rtl/whack_detector.sv
// Whack-a-mole player input path: per-button sync + debounce, press encoding,
// one judgment per mole appearance, saturating score/miss counters.

module whack_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2, lvl, lvl_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
      // the flip lands on the DEBOUNCE_CYCLES-th consecutive differing sample
      if (s2 != lvl) begin
        if (cnt == CNT_LAST) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module whack_detector #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic [4:0] mole,
  input  logic       mole_valid,
  input  logic       score_clr,
  output logic       hit,
  output logic       miss,
  output logic [2:0] hit_idx,
  output logic [7:0] score,
  output logic [7:0] miss_count
);
  localparam int NUM_LANES = 5;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [NUM_LANES-1:0] ev;
  logic [NUM_LANES-1:0] mole_q;
  logic [1:0]           state;
  logic [2:0]           ev_idx;
  logic                 ev_one, judge, judge_hit;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    whack_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[gi]),
      .press(ev[gi])
    );
  end

  always_comb begin
    ev_one = $onehot(ev);
    ev_idx = 3'b111;
    if (ev_one) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (ev[i]) ev_idx = 3'(i);
    end
  end

  // a single press equal to the pattern implies the pattern is one-hot too
  assign judge     = (state == ARMED) && (|ev);
  assign judge_hit = ev_one && (ev == mole) && mole_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mole_q  <= '0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      hit_idx <= 3'b111;
    end else begin
      hit  <= judge & judge_hit;
      miss <= judge & ~judge_hit;
      if (judge) hit_idx <= ev_idx;
      case (state)
        IDLE: if (mole_valid) begin
          state  <= ARMED;
          mole_q <= mole;
        end
        ARMED: begin
          if (mole != mole_q) mole_q <= mole;
          if (!mole_valid)    state  <= IDLE;
          else if (|ev)       state  <= LOCKED;
        end
        LOCKED: begin
          if (!mole_valid) begin
            state <= IDLE;
          end else if (mole != mole_q) begin
            state  <= ARMED;
            mole_q <= mole;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || score_clr) begin
      score      <= '0;
      miss_count <= '0;
    end else begin
      if (judge && judge_hit && score != 8'hFF)       score      <= score + 1'b1;
      if (judge && !judge_hit && miss_count != 8'hFF) miss_count <= miss_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_whack_detector.sv
// Directed bench for whack_detector with DEBOUNCE_CYCLES = 4 (judgment at edge 7).

module tb_whack_detector;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw, mole;
  logic       mole_valid, score_clr;
  logic       hit, miss;
  logic [2:0] hit_idx;
  logic [7:0] score, miss_count;

  int total = 0;
  int bad   = 0;

  whack_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .mole      (mole),
    .mole_valid(mole_valid),
    .score_clr (score_clr),
    .hit       (hit),
    .miss      (miss),
    .hit_idx   (hit_idx),
    .score     (score),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mole;
    logic       mv;
    logic [4:0] btn;
    logic       eh;
    logic       em;
    logic [2:0] eidx;
    int         es;
    int         emc;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".hit"},   int'(hit), 0);
    chk({nm, ".miss"},  int'(miss), 0);
    chk({nm, ".idx"},   int'(hit_idx), 7);
    chk({nm, ".score"}, int'(score), 0);
    chk({nm, ".mcnt"},  int'(miss_count), 0);
  endtask

  // caller has just made the inputs visible before edge 0
  task automatic judge_wait(input logic clr, output logic early, output logic h,
                            output logic m, output logic [2:0] idx);
    early = 1'b0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      if (hit || miss) early = 1'b1;
    end
    if (clr) score_clr = 1'b1;
    @(posedge clk); #1;
    h = hit; m = miss; idx = hit_idx;
    score_clr = 1'b0;
  endtask

  task automatic set_mole(input logic [4:0] m, input logic mv);
    @(negedge clk);
    mole = m; mole_valid = mv;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn_raw = '0;
    repeat (10) @(posedge clk);
  endtask

  task automatic check_press(input string nm, input logic [4:0] b, input logic clr,
                             input logic eh, input logic em, input logic [2:0] eidx,
                             input int es, input int emc);
    logic early, h, m;
    logic [2:0] idx;
    @(negedge clk);
    btn_raw = b;
    judge_wait(clr, early, h, m, idx);
    chk({nm, ".early"}, int'(early), 0);
    chk({nm, ".hit"},   int'(h), int'(eh));
    chk({nm, ".miss"},  int'(m), int'(em));
    chk({nm, ".idx"},   int'(idx), int'(eidx));
    chk({nm, ".score"}, int'(score), es);
    chk({nm, ".mcnt"},  int'(miss_count), emc);
    @(posedge clk); #1;
    chk({nm, ".oneshot"}, int'(hit | miss), 0);
    release_btn();
  endtask

  initial begin
    logic seen, early, h, m;
    logic [2:0] idx;

    //          mole      mv    btn       hit   miss  idx   score mcnt
    vt[0] = '{5'b00100, 1'b1, 5'b00100, 1'b1, 1'b0, 3'd2, 1, 0};
    vt[1] = '{5'b10000, 1'b1, 5'b00001, 1'b0, 1'b1, 3'd0, 1, 1};
    vt[2] = '{5'b10000, 1'b1, 5'b10000, 1'b0, 1'b0, 3'd0, 1, 1}; // locked out
    vt[3] = '{5'b00010, 1'b1, 5'b00010, 1'b1, 1'b0, 3'd1, 2, 1};
    vt[4] = '{5'b01000, 1'b1, 5'b01010, 1'b0, 1'b1, 3'd7, 2, 2}; // multi-press
    vt[5] = '{5'b00000, 1'b1, 5'b00100, 1'b0, 1'b1, 3'd2, 2, 3}; // no mole lit
    vt[6] = '{5'b00001, 1'b0, 5'b00001, 1'b0, 1'b0, 3'd2, 2, 3}; // idle, ignored
    vt[7] = '{5'b00001, 1'b1, 5'b00001, 1'b1, 1'b0, 3'd0, 3, 3};
    vt[8] = '{5'b00011, 1'b1, 5'b00001, 1'b0, 1'b1, 3'd0, 3, 4}; // not one-hot

    rst_n = 1'b0; btn_raw = '0; mole = '0; mole_valid = 1'b0; score_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_mole(vt[i].mole, vt[i].mv);
      check_press($sformatf("vec%0d", i), vt[i].btn, 1'b0, vt[i].eh, vt[i].em,
                  vt[i].eidx, vt[i].es, vt[i].emc);
    end

    // 3-cycle glitch must not produce an event; a following real press still takes full latency
    set_mole(5'b00100, 1'b1);
    @(negedge clk) btn_raw = 5'b00100;
    repeat (3) @(negedge clk);
    btn_raw = '0;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (hit || miss) seen = 1'b1;
    end
    chk("glitch.pulse", int'(seen), 0);
    chk("glitch.score", int'(score), 3);
    chk("glitch.mcnt",  int'(miss_count), 4);
    check_press("after_glitch", 5'b00100, 1'b0, 1'b1, 1'b0, 3'd2, 4, 4);

    // reset mid-count, button held through release
    @(negedge clk) btn_raw = 5'b00001;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset("midrst");
    @(negedge clk);
    mole = 5'b00001; mole_valid = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    judge_wait(1'b0, early, h, m, idx);
    chk("held.early", int'(early), 0);
    chk("held.hit",   int'(h), 1);
    chk("held.idx",   int'(idx), 0);
    chk("held.score", int'(score), 1);
    release_btn();

    // saturation
    @(negedge clk) score_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr.score", int'(score), 0);
    chk("clr.mcnt",  int'(miss_count), 0);
    score_clr = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      logic [4:0] mb;
      mb = (k % 2 == 1) ? 5'b00010 : 5'b00001;
      set_mole(mb, 1'b1);
      check_press($sformatf("sat%0d", k), mb, 1'b0, 1'b1, 1'b0,
                  (k % 2 == 1) ? 3'd1 : 3'd0, (k > 255) ? 255 : k, 0);
    end

    // clear wins over a coincident hit
    set_mole(5'b00010, 1'b1);
    check_press("clr_vs_hit", 5'b00010, 1'b1, 1'b1, 1'b0, 3'd1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/whack_detector.md
# whack_detector

Player-input side of the mole display path. It takes the five raw whack buttons and synchronizes and debounces each one, then turns each new press into a 3-bit position index. Each press is judged against the one-hot mole pattern currently driven to the LEDs. The result is hit/miss pulses and saturating score and miss counters for the game controller and score display.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a button level change (5 ms at 50 MHz). Benches override it to 4.
- CNT_W, derived as clog2(DEBOUNCE_CYCLES+1): debounce counter width. Not user-set.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- btn_raw  in  5  raw buttons, active-high, asynchronous to clk. Bit i is position i.
- mole  in  5  current LED pattern, one-hot. Bit i lit means a mole is at position i.
- mole_valid  in  1  high while a round is running and `mole` is meaningful.
- score_clr  in  1  synchronous clear of `score` and `miss_count`.
- hit  out  1  one-cycle pulse: correct single press on the lit mole.
- miss  out  1  one-cycle pulse: wrong, multiple, or no-mole press.
- hit_idx  out  3  encoded press position 0–4, valid with `hit` or `miss`. 3'b111 means multiple presses or none.
- score  out  8  hit count, saturates at 255.
- miss_count  out  8  miss count, saturates at 255.

## Operation

Input conditioning, per button:
- A 2-FF synchronizer feeds a debouncer holding a debounced level and a CNT_W counter.
- When the synchronized value differs from the debounced level, the counter increments. Otherwise it clears to 0.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A press event is a 0→1 transition of the debounced level, registered for one cycle. Releases generate nothing.

Encoding:
- Exactly one press event on bit i gives idx = i.
- Two or more simultaneous events give idx = 3'b111.

State machine:
- IDLE → ARMED when mole_valid = 1. The current `mole` is latched into mole_q. Press events in IDLE are discarded.
- ARMED, press event(s) present: go to LOCKED.
  - Judged a hit if there is exactly one event, its bit is set in `mole`, and mole_valid = 1.
  - Any other press is a miss. This covers multiple presses, the wrong bit, and `mole` = 0 or not one-hot.
  - This gives one judgment per mole appearance.
- LOCKED: press events are discarded.
  - `mole` ≠ mole_q with mole_valid = 1 → ARMED, and mole_q reloads.
  - mole_valid = 0 → IDLE.
- ARMED, mole_valid = 0 → IDLE. mole_valid low dominates in every state.
- ARMED, `mole` changes with no press: mole_q reloads and the state stays ARMED.

Counters:
- `score` increments on `hit`; `miss_count` increments on `miss`. Both hold at 255 when saturated.
- `score_clr` forces both to 0 and wins over a coincident increment.
- `score_clr` does not affect the FSM or the debouncers.

## Timing

Reset values:
- hit = 0, miss = 0, hit_idx = 3'b111, score = 0, miss_count = 0.
- State IDLE, mole_q = 0.
- Sync FFs, debounced levels and counters all 0.

Latency:
- btn_raw goes high and is held stable. The first clock edge that samples it high is edge 0.
- `hit`/`miss` is high for exactly the cycle after edge DEBOUNCE_CYCLES+3: 2 synchronizer edges, DEBOUNCE_CYCLES counting edges, 1 for event registration and judgment.
- `hit_idx` and the counter update are coincident with the pulse. `hit_idx` holds its value until the next judgment.

Debounce edge cases:
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no event; the counter restarts.
- A button held continuously gives exactly one event.

Reset and mole timing:
- Reset asserted mid-count or mid-round returns everything to its reset values on the next edge.
- A button held through reset release is seen as a new press DEBOUNCE_CYCLES+3 edges later.
- The judgment uses `mole` and mole_valid sampled on the same edge as the press event. A mole change on that edge takes effect for judgment and then the FSM moves to LOCKED. mole_q still updates if the state is ARMED.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

1. **Single hit.** mole_valid = 1, mole = 5'b00100, btn_raw = 5'b00100 held → hit pulses 1 cycle at edge 7; hit_idx = 2; score = 1; miss_count = 0.
2. **Wrong button, then lockout.** mole = 5'b10000, press bit 0 → miss; hit_idx = 0; miss_count = 1. A second press on bit 4 with mole unchanged → no pulse. Change mole to 5'b00010 and press bit 1 → hit; hit_idx = 1.
3. **Glitch and multi-press.** A 3-cycle btn_raw pulse → no event, counters unchanged. Bits 1 and 3 rising on the same cycle → miss; hit_idx = 3'b111.
4. **IDLE and no-mole cases.** Press with mole_valid = 0 → no pulse, state IDLE. mole_valid = 1, mole = 5'b00000, press bit 2 → miss.
5. **Saturation and clear.** Run 256 hits → score = 255 after the 255th and stays 255. score_clr coincident with a hit → score = 0.
6. **Reset mid-operation.** Assert rst_n = 0 during a debounce count → all outputs at reset values next edge. Hold a button through reset release → event at edge 7 after release.
